// File: rtl/add8se_share_arb_if.sv
// Requester/response bundle for the shared adder arbiter.
// master: requester side plus response consumer. slave: the arbiter.
interface add8se_share_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) ();
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [8:0]        rsp_sum;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum
  );
endinterface

// File: rtl/add8se_share_arb.sv
// Round-robin arbiter and two-stage pipeline sharing one external
// combinational 8-bit signed adder among NREQ requesters.
// S1 holds the granted operand pair (drives the adder), S2 captures the sum.

// Per-requester accept: asserted only for the granted lane.
module add8se_share_arb_lane #(
  parameter int IDW  = 2,
  parameter int LANE = 0
) (
  input  logic [IDW-1:0] grant,
  input  logic           en,
  output logic           ready
);
  assign ready = en && (grant == IDW'(LANE));
endmodule

module add8se_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  add8se_share_arb_if.slave   bus,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  input  logic [8:0]          add_o,
  input  logic                clr_cnt,
  output logic [15:0]         op_cnt,
  output logic                busy
);

  logic           s1_vld_q, s1_vld_d;
  logic [7:0]     s1_a_q, s1_a_d;
  logic [7:0]     s1_b_q, s1_b_d;
  logic [IDW-1:0] s1_id_q, s1_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [8:0]     rsp_sum_q, rsp_sum_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [15:0]    op_cnt_q, op_cnt_d;

  logic           s2_adv, s1_adv;
  logic           any_valid, hs, lane_en;
  logic [IDW-1:0] grant;

  assign s2_adv    = !rsp_valid_q || bus.rsp_ready;
  assign s1_adv    = !s1_vld_q || s2_adv;
  assign any_valid = |bus.req_valid;
  assign hs        = any_valid && s1_adv;
  // No grant may be offered while reset is held, so ready is gated by rst_n.
  assign lane_en   = hs && rst_n;

  // Round-robin search starting at ptr, wrapping modulo NREQ.
  always_comb begin
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && bus.req_valid[idx]) begin
        grant = IDW'(idx);
        found = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      add8se_share_arb_lane #(.IDW(IDW), .LANE(gi)) u_lane (
        .grant (grant),
        .en    (lane_en),
        .ready (bus.req_ready[gi])
      );
    end
  endgenerate

  // Next state for both pipeline stages, the pointer and the op counter.
  always_comb begin
    s1_vld_d    = s1_vld_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_id_d     = s1_id_q;
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
    op_cnt_d    = op_cnt_q;

    if (s1_adv) begin
      s1_vld_d = hs;
      if (hs) begin
        s1_a_d  = bus.req_a[int'(grant)*8 +: 8];
        s1_b_d  = bus.req_b[int'(grant)*8 +: 8];
        s1_id_d = grant;
        ptr_d   = (grant == IDW'(NREQ-1)) ? '0 : grant + IDW'(1);
      end
    end

    if (s2_adv) begin
      rsp_valid_d = s1_vld_q;
      if (s1_vld_q) begin
        rsp_sum_d = add_o;
        rsp_id_d  = s1_id_q;
      end
    end

    if (clr_cnt)
      op_cnt_d = '0;
    else if (rsp_valid_q && bus.rsp_ready && op_cnt_q != 16'hFFFF)
      op_cnt_d = op_cnt_q + 16'd1;
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q    <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
      op_cnt_q    <= '0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_id_q     <= s1_id_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
      op_cnt_q    <= op_cnt_d;
    end
  end

  // Idle operands are zeroed so the shared adder does not toggle.
  assign add_a         = s1_vld_q ? s1_a_q : 8'h00;
  assign add_b         = s1_vld_q ? s1_b_q : 8'h00;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_id    = rsp_id_q;
  assign op_cnt        = op_cnt_q;
  assign busy          = s1_vld_q || rsp_valid_q;

endmodule

// File: tb/tb_add8se_share_arb.sv
// Bench for add8se_share_arb: exact adder core, scoreboard monitor on the
// falling edge, directed scenarios plus a randomized phase.
module tb_add8se_share_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  add_a, add_b;
  logic [8:0]  add_o;
  logic        clr_cnt = 1'b0;
  logic [15:0] op_cnt;
  logic        busy;

  add8se_share_arb_if #(.NREQ(NREQ), .IDW(IDW)) bif ();

  add8se_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bif),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_o   (add_o),
    .clr_cnt (clr_cnt),
    .op_cnt  (op_cnt),
    .busy    (busy)
  );

  // Exact signed adder core plugged into the add_* ports.
  assign add_o = {add_a[7], add_a} + {add_b[7], add_b};

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [IDW-1:0] id;
    logic [8:0]     sum;
  } exp_t;

  exp_t        sb[$];
  int          rr_ptr = 0;
  logic [15:0] exp_cnt = '0;
  logic        hold = 1'b0;
  logic [IDW-1:0] hold_id;
  logic [8:0]  hold_sum;

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      rr_ptr  = 0;
      exp_cnt = '0;
      hold    = 1'b0;
    end else begin
      int g;
      logic [NREQ-1:0] exp_rdy;
      chk("op_cnt", 32'(op_cnt), 32'(exp_cnt));
      chk("busy", 32'(busy), 32'(sb.size() != 0));
      if (sb.size() > 2) chk("capacity", 32'(sb.size()), 32'd2);
      if (hold) begin
        chk("hold_valid", 32'(bif.rsp_valid), 32'd1);
        chk("hold_id", 32'(bif.rsp_id), 32'(hold_id));
        chk("hold_sum", 32'(bif.rsp_sum), 32'(hold_sum));
      end
      g = rr_pick(bif.req_valid, rr_ptr);
      exp_rdy = '0;
      if (g >= 0 && (sb.size() < 2 || bif.rsp_ready)) exp_rdy[g] = 1'b1;
      chk("req_ready", 32'(bif.req_ready), 32'(exp_rdy));
      if (bif.rsp_valid && bif.rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_id", 32'(bif.rsp_id), 32'(e.id));
          chk("rsp_sum", 32'(bif.rsp_sum), 32'(e.sum));
        end
      end
      if ((bif.req_valid & bif.req_ready) != '0 && g >= 0) begin
        exp_t e;
        int sa, sb_;
        logic [7:0] a, b;
        a   = bif.req_a[g*8 +: 8];
        b   = bif.req_b[g*8 +: 8];
        sa  = $signed(a);
        sb_ = $signed(b);
        e.id  = IDW'(g);
        e.sum = 9'(sa + sb_);
        sb.push_back(e);
        rr_ptr = (g + 1) % NREQ;
      end
      hold     = bif.rsp_valid && !bif.rsp_ready;
      hold_id  = bif.rsp_id;
      hold_sum = bif.rsp_sum;
      if (clr_cnt) exp_cnt = '0;
      else if (bif.rsp_valid && bif.rsp_ready && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bif.req_valid = '0;
    bif.rsp_ready = 1'b1;
    repeat (4) step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rsp_valid"}, 32'(bif.rsp_valid), 32'd0);
    chk({tag, "_rsp_id"}, 32'(bif.rsp_id), 32'd0);
    chk({tag, "_rsp_sum"}, 32'(bif.rsp_sum), 32'd0);
    chk({tag, "_req_ready"}, 32'(bif.req_ready), 32'd0);
    chk({tag, "_add_a"}, 32'(add_a), 32'd0);
    chk({tag, "_add_b"}, 32'(add_b), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_op_cnt"}, 32'(op_cnt), 32'd0);
  endtask

  task automatic do_single(input int id, input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp_sum);
    logic [15:0] cnt0;
    logic [NREQ-1:0] one;
    one = '0;
    one[id] = 1'b1;
    step();
    bif.req_valid = one;
    bif.req_a[id*8 +: 8] = a;
    bif.req_b[id*8 +: 8] = b;
    bif.rsp_ready = 1'b1;
    @(negedge clk);
    chk("single_ready", 32'(bif.req_ready), 32'(one));
    cnt0 = op_cnt;
    step();
    bif.req_valid = '0;
    @(negedge clk);
    chk("single_lat_early", 32'(bif.rsp_valid), 32'd0);
    @(negedge clk);
    chk("single_lat_valid", 32'(bif.rsp_valid), 32'd1);
    chk("single_id", 32'(bif.rsp_id), 32'(id));
    chk("single_sum", 32'(bif.rsp_sum), 32'(exp_sum));
    @(negedge clk);
    chk("single_add_a_idle", 32'(add_a), 32'd0);
    chk("single_add_b_idle", 32'(add_b), 32'd0);
    chk("single_busy_idle", 32'(busy), 32'd0);
    chk("single_cnt", 32'(op_cnt), 32'(cnt0 + 16'd1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NREQ-1:0] hsv;
    int nhs;
    int ids[$];
    bif.req_valid = '0;
    bif.req_a     = '0;
    bif.req_b     = '0;
    bif.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    step();
    rst_n = 1'b1;

    // Round-robin with all requesters valid.
    bif.req_a = $urandom;
    bif.req_b = $urandom;
    bif.rsp_ready = 1'b1;
    step();
    bif.req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      logic [NREQ-1:0] exp1;
      exp1 = '0;
      exp1[i % NREQ] = 1'b1;
      @(negedge clk);
      chk("rr_grant", 32'(bif.req_ready), 32'(exp1));
      if (i >= 2) begin
        chk("rr_rsp_valid", 32'(bif.rsp_valid), 32'd1);
        chk("rr_rsp_id", 32'(bif.rsp_id), 32'((i - 2) % NREQ));
      end
      step();
      bif.req_a = $urandom;
      bif.req_b = $urandom;
    end
    drain();

    // Backpressure: requesters 0,1,3, response stalled for 5 cycles.
    bif.req_valid = 4'b1011;
    bif.req_a = $urandom;
    bif.req_b = $urandom;
    bif.rsp_ready = 1'b0;
    nhs = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      hsv = bif.req_valid & bif.req_ready;
      nhs += $countones(hsv);
      if (bif.rsp_valid) chk("bp_hold_id0", 32'(bif.rsp_id), 32'd0);
      if (c >= 2) chk("bp_ready_zero", 32'(bif.req_ready), 32'd0);
      step();
      bif.req_valid = bif.req_valid & ~hsv;
    end
    chk("bp_hs_count", 32'(nhs), 32'd2);
    bif.rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      hsv = bif.req_valid & bif.req_ready;
      if (bif.rsp_valid && bif.rsp_ready) ids.push_back(int'(bif.rsp_id));
      step();
      bif.req_valid = bif.req_valid & ~hsv;
    end
    chk("bp_rsp_count", 32'(ids.size()), 32'd3);
    if (ids.size() == 3) begin
      chk("bp_order0", 32'(ids[0]), 32'd0);
      chk("bp_order1", 32'(ids[1]), 32'd1);
      chk("bp_order2", 32'(ids[2]), 32'd3);
    end
    drain();

    // Single request and sign-extension cases.
    do_single(2, 8'h05, 8'h03, 9'h008);
    do_single(0, 8'h80, 8'hFF, 9'h17F);
    do_single(1, 8'h7F, 8'h01, 9'h080);
    drain();

    // Randomized traffic with random backpressure and occasional clears.
    for (int c = 0; c < 400; c++) begin
      bif.req_valid = NREQ'($urandom);
      bif.req_a     = $urandom;
      bif.req_b     = $urandom;
      bif.rsp_ready = ($urandom_range(0, 3) != 0);
      clr_cnt       = ($urandom_range(0, 49) == 0);
      step();
    end
    clr_cnt = 1'b0;
    drain();
    chk("rand_drained", 32'(sb.size()), 32'd0);

    // Counter saturation and clear priority.
    force dut.op_cnt_q = 16'hFFFE;
    exp_cnt = 16'hFFFE;
    #1;
    release dut.op_cnt_q;
    bif.req_valid = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      bif.req_a = $urandom;
      bif.req_b = $urandom;
      step();
    end
    @(negedge clk);
    chk("sat_hold", 32'(op_cnt), 32'hFFFF);
    step();
    clr_cnt = 1'b1;
    @(negedge clk);
    chk("clr_with_rsp", 32'(bif.rsp_valid && bif.rsp_ready), 32'd1);
    step();
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_cnt", 32'(op_cnt), 32'd0);
    step();
    drain();

    // Reset asserted while both stages are full.
    bif.req_valid = '1;
    bif.rsp_ready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("full_busy", 32'(busy && bif.rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    bif.req_valid = 4'b1000;
    #1;
    chk_all_zero("midrst");
    bif.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_grant3", 32'(bif.req_ready), 32'b1000);
    step();
    bif.req_valid = '1;
    @(negedge clk);
    chk("post_rst_grant0", 32'(bif.req_ready), 32'b0001);
    step();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end
endmodule
